order_gateway: RTL

Consumer end of the decision stream produced by the trading pipeline top.
- Accepts (signal, allow_trade, kill_switch) beats over valid/ready.
- Converts qualifying beats into single buy/sell order beats on an output valid/ready stream.
- Enforces a post-order cooldown and a latched kill-switch halt cleared only by explicit software clear.

---
 rtl/fxp_pkg.sv | 19 +
 rtl/order_qty_calc.sv | 23 ++
 rtl/order_gateway.sv | 107 ++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point trading types: order side, gateway state and order field widths.
package fxp_pkg;

   localparam int unsigned ORD_QTY_W = 16;
   localparam int unsigned ORD_SEQ_W = 16;

   typedef enum logic {
      BUY  = 1'b0,
      SELL = 1'b1
   } order_side_e;

   typedef enum logic [1:0] {
      GW_IDLE,
      GW_ISSUE,
      GW_COOLDOWN,
      GW_HALTED
   } gw_state_e;

endpackage

// File: rtl/order_qty_calc.sv
// Lot quantity from a Q16.16 signal: |signal| >> QTY_SHIFT, clipped to the qty width.
module order_qty_calc
   import fxp_pkg::*;
#(
   parameter int unsigned QTY_SHIFT = 8
) (
   input  logic [31:0]          signal_in,
   output logic [ORD_QTY_W-1:0] qty
);

   logic [32:0] sig_ext;
   logic [32:0] mag;
   logic [32:0] shifted;

   // 33-bit magnitude so that -2^31 does not overflow back to negative
   always_comb begin
      sig_ext = {signal_in[31], signal_in};
      mag     = sig_ext[32] ? (33'd0 - sig_ext) : sig_ext;
      shifted = mag >> QTY_SHIFT;
      qty     = (|shifted[32:ORD_QTY_W]) ? '1 : shifted[ORD_QTY_W-1:0];
   end

endmodule

// File: rtl/order_gateway.sv
// Turns qualifying decision beats into buy/sell orders, with post-order cooldown and latched kill halt.
module order_gateway
   import fxp_pkg::*;
#(
   parameter logic signed [31:0] BUY_THRESH  = 32'sh0000_8000,
   parameter logic signed [31:0] SELL_THRESH = -32'sh0000_8000,
   parameter int unsigned        QTY_SHIFT   = 8,
   parameter int unsigned        COOLDOWN    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          signal_in,
   input  logic                 allow_trade_in,
   input  logic                 kill_switch_in,
   output logic                 ord_valid,
   input  logic                 ord_ready,
   output logic                 ord_side,
   output logic [ORD_QTY_W-1:0] ord_qty,
   output logic [ORD_SEQ_W-1:0] ord_seq,
   input  logic                 halt_clear,
   output logic                 halted,
   output logic [15:0]          drop_count
);

   gw_state_e             state, state_nx;
   order_side_e           side_q;
   logic [15:0]           cd_cnt;
   logic [ORD_QTY_W-1:0]  qty_calc;
   logic                  accept;
   logic                  is_buy;
   logic                  is_sell;
   logic                  dropping;

   order_qty_calc #(
      .QTY_SHIFT(QTY_SHIFT)
   ) u_qty (
      .signal_in(signal_in),
      .qty      (qty_calc)
   );

   assign is_buy  = $signed(signal_in) >= BUY_THRESH;
   assign is_sell = $signed(signal_in) <= SELL_THRESH;

   always_comb begin
      state_nx  = state;
      in_ready  = !rst && (state != GW_ISSUE);
      accept    = in_valid && in_ready;
      ord_valid = (state == GW_ISSUE);
      halted    = (state == GW_HALTED);
      dropping  = accept && ((state == GW_COOLDOWN) || (state == GW_HALTED));
      case (state)
         GW_IDLE: begin
            if (accept) begin
               if (kill_switch_in)
                  state_nx = GW_HALTED;
               else if (allow_trade_in && (is_buy || is_sell))
                  state_nx = GW_ISSUE;
            end
         end
         GW_ISSUE: begin
            if (ord_ready)
               state_nx = (COOLDOWN == 0) ? GW_IDLE : GW_COOLDOWN;
         end
         GW_COOLDOWN: begin
            if (accept && kill_switch_in)
               state_nx = GW_HALTED;
            else if (cd_cnt <= 16'd1)
               state_nx = GW_IDLE;
         end
         GW_HALTED: begin
            if (halt_clear && !(accept && kill_switch_in))
               state_nx = GW_IDLE;
         end
         default: state_nx = GW_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= GW_IDLE;
         side_q     <= BUY;
         ord_qty    <= '0;
         ord_seq    <= '0;
         drop_count <= '0;
         cd_cnt     <= '0;
      end else begin
         state <= state_nx;
         if ((state == GW_IDLE) && (state_nx == GW_ISSUE)) begin
            side_q  <= is_buy ? BUY : SELL;
            ord_qty <= qty_calc;
         end
         if ((state == GW_ISSUE) && ord_ready) begin
            ord_seq <= ord_seq + 16'd1;
            cd_cnt  <= 16'(COOLDOWN);
         end else if ((state == GW_COOLDOWN) && (cd_cnt != '0)) begin
            cd_cnt <= cd_cnt - 16'd1;
         end
         if (dropping && (drop_count != '1))
            drop_count <= drop_count + 16'd1;
      end
   end

   assign ord_side = side_q;

endmodule
